byte_packer: RTL



---
 rtl/byte_packer_pkg.sv | 30 +++
 rtl/byte_lane_writer.sv | 26 ++
 rtl/byte_packer.sv | 103 ++++++++++
 3 files changed

// File: rtl/byte_packer_pkg.sv
// rtl/byte_packer_pkg.sv - shared word/byte geometry and state types for the byte packer
package byte_packer_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = WORD_W / BYTE_W;

  // Lane 0 is the most significant byte; the word splitter uses the same mapping.
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    B1    = 2'd1,
    B2    = 2'd2,
    B3    = 2'd3
  } cnt_e;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } ostate_e;

  function automatic int lane_lsb(input int lane);
    return WORD_W - BYTE_W * (lane + 1);
  endfunction

endpackage

// File: rtl/byte_lane_writer.sv
// rtl/byte_lane_writer.sv - writes one byte into lane cnt of the accumulator, pads higher lanes
module byte_lane_writer
  import byte_packer_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
  input  logic [WORD_W-1:0] acc_i,
  input  logic [1:0]        cnt_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] acc_o
);

  always_comb begin
    acc_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(cnt_i)) begin
        acc_o[lane_lsb(k) +: BYTE_W] = acc_i[lane_lsb(k) +: BYTE_W];
      end else if (k == int'(cnt_i)) begin
        acc_o[lane_lsb(k) +: BYTE_W] = byte_i;
      end else begin
        acc_o[lane_lsb(k) +: BYTE_W] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a valid/ready byte stream into 32-bit words, first byte in [31:24]
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int                WORD_BYTES = 4,
  parameter logic [BYTE_W-1:0] PAD_BYTE   = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [2:0]        out_nbytes,
  output logic              out_last
);

  if (WORD_BYTES != LANES) begin : g_bad_word_bytes
    $error("byte_packer: only WORD_BYTES=4 is supported");
  end

  localparam logic [WORD_W-1:0] PAD_WORD = {LANES{PAD_BYTE}};

  cnt_e              cnt_q, cnt_d;
  ostate_e           ostate_q, ostate_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] acc_wr;
  logic              in_fire, out_fire;

  byte_lane_writer #(.PAD_BYTE(PAD_BYTE)) u_lane_writer (
    .acc_i  (acc_q),
    .cnt_i  (cnt_q),
    .byte_i (in_byte),
    .acc_o  (acc_wr)
  );

  assign out_valid  = (ostate_q == FULL);
  assign in_ready   = !out_valid || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign out_word   = word_q;
  assign out_nbytes = nbytes_q;
  assign out_last   = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= EMPTY;
      ostate_q <= IDLE;
      acc_q    <= '0;
      word_q   <= '0;
      nbytes_q <= '0;
      last_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ostate_q <= ostate_d;
      acc_q    <= acc_d;
      word_q   <= word_d;
      nbytes_q <= nbytes_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    ostate_d = ostate_q;
    acc_d    = acc_q;
    word_d   = word_q;
    nbytes_d = nbytes_q;
    last_d   = last_q;
    if (clr) begin
      // Clear wins over both handshakes; a byte accepted this cycle is dropped.
      cnt_d    = EMPTY;
      acc_d    = PAD_WORD;
      ostate_d = IDLE;
      last_d   = 1'b0;
    end else begin
      if (out_fire) begin
        ostate_d = IDLE;
      end
      if (in_fire) begin
        if (cnt_q == B3 || in_last) begin
          word_d   = acc_wr;
          nbytes_d = {1'b0, cnt_q} + 3'd1;
          last_d   = in_last;
          ostate_d = FULL;
          acc_d    = PAD_WORD;
          cnt_d    = EMPTY;
        end else begin
          acc_d = acc_wr;
          cnt_d = cnt_e'(cnt_q + 2'd1);
        end
      end
    end
  end

endmodule
